// File: rtl/turret_sched_pkg.sv
// Shared constants and types for the turret sprite scheduler.
// Sprite geometry, palette width, per-instance config record and FSM states.
package turret_sched_pkg;
  localparam int SPR_W           = 43;
  localparam int SPR_H           = 34;
  localparam int IDX_W           = 3;
  localparam int TRANSPARENT_IDX = 0;

  typedef struct packed {
    logic [9:0] x;
    logic [9:0] y;
    logic       en;
  } turret_cfg_t;

  typedef enum logic {
    COLLECT = 1'b0,
    PENDING = 1'b1
  } sched_state_t;
endpackage

// File: rtl/turret_hit_test.sv
// Bounding-box test of the current pixel against one turret instance.
// Offsets are unsigned, so pixels left of or above the sprite wrap to large values and miss.
module turret_hit_test
  import turret_sched_pkg::*;
(
  input  logic [9:0]  DrawX,
  input  logic [9:0]  DrawY,
  input  turret_cfg_t cfg,
  output logic        hit,
  output logic [10:0] dx,
  output logic [10:0] dy
);
  assign dx  = {1'b0, DrawX} - {1'b0, cfg.x};
  assign dy  = {1'b0, DrawY} - {1'b0, cfg.y};
  assign hit = cfg.en && (dx < 11'(SPR_W)) && (dy < 11'(SPR_H));
endmodule

// File: rtl/turret_sprite_scheduler.sv
// Shares one turret sprite ROM among N instances: picks the winning instance per pixel,
// addresses the ROM and aligns its texel to a fixed 3-cycle pixel pipeline.
//
// state   | meaning
// COLLECT | shadow registers accept config writes; cfg_ready high
// PENDING | commit requested; waiting for frame start to copy shadow -> active
module turret_sprite_scheduler
  import turret_sched_pkg::*;
#(
  parameter  int N_TURRETS = 4,
  localparam int ID_W      = $clog2(N_TURRETS)
) (
  input  logic             vga_clk,
  input  logic             reset_n,
  input  logic [9:0]       DrawX,
  input  logic [9:0]       DrawY,
  input  logic             blank,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [ID_W-1:0]  cfg_id,
  input  logic [9:0]       cfg_x,
  input  logic [9:0]       cfg_y,
  input  logic             cfg_en,
  input  logic             cfg_commit,
  output logic [10:0]      rom_address,
  input  logic [IDX_W-1:0] rom_q,
  output logic             pix_valid,
  output logic [IDX_W-1:0] pix_index,
  output logic [ID_W-1:0]  pix_id
);
  sched_state_t state;
  turret_cfg_t  shadow [N_TURRETS];
  turret_cfg_t  active [N_TURRETS];

  logic [N_TURRETS-1:0] raw_hit;
  logic [10:0]          dx_vec [N_TURRETS];
  logic [10:0]          dy_vec [N_TURRETS];

  logic            any_hit;
  logic [ID_W-1:0] win_id;
  logic [10:0]     win_dx;
  logic [10:0]     win_dy;
  logic [10:0]     addr_c;

  logic            hit_d1, hit_d2;
  logic [ID_W-1:0] id_d1, id_d2;
  logic            opaque;

  wire frame_start = (DrawX == 10'd0) && (DrawY == 10'd0);

  for (genvar gi = 0; gi < N_TURRETS; gi++) begin : g_hit
    turret_hit_test u_hit (
      .DrawX (DrawX),
      .DrawY (DrawY),
      .cfg   (active[gi]),
      .hit   (raw_hit[gi]),
      .dx    (dx_vec[gi]),
      .dy    (dy_vec[gi])
    );
  end

  // Walk from highest to lowest ID so the lowest-numbered hit is left standing.
  always_comb begin
    any_hit = 1'b0;
    win_id  = '0;
    win_dx  = '0;
    win_dy  = '0;
    for (int i = N_TURRETS - 1; i >= 0; i--) begin
      if (raw_hit[i] && blank) begin
        any_hit = 1'b1;
        win_id  = ID_W'(i);
        win_dx  = dx_vec[i];
        win_dy  = dy_vec[i];
      end
    end
  end

  assign addr_c = win_dy * 11'(SPR_W) + win_dx;

  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= COLLECT;
      cfg_ready <= 1'b1;
      for (int i = 0; i < N_TURRETS; i++) begin
        shadow[i] <= '0;
        active[i] <= '0;
      end
    end else begin
      case (state)
        COLLECT: begin
          if (cfg_valid) shadow[cfg_id] <= '{x: cfg_x, y: cfg_y, en: cfg_en};
          if (cfg_commit) begin
            state     <= PENDING;
            cfg_ready <= 1'b0;
          end
        end
        PENDING: begin
          if (frame_start) begin
            for (int i = 0; i < N_TURRETS; i++) active[i] <= shadow[i];
            state     <= COLLECT;
            cfg_ready <= 1'b1;
          end
        end
        default: begin
          state     <= COLLECT;
          cfg_ready <= 1'b1;
        end
      endcase
    end
  end

  // Transparency is judged only on the winner; a clear texel never falls through.
  assign opaque = hit_d2 && (rom_q != IDX_W'(TRANSPARENT_IDX));

  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      hit_d1      <= 1'b0;
      id_d1       <= '0;
      rom_address <= '0;
      hit_d2      <= 1'b0;
      id_d2       <= '0;
      pix_valid   <= 1'b0;
      pix_index   <= '0;
      pix_id      <= '0;
    end else begin
      hit_d1      <= any_hit;
      id_d1       <= win_id;
      rom_address <= any_hit ? addr_c : 11'd0;
      hit_d2      <= hit_d1;
      id_d2       <= id_d1;
      pix_valid   <= opaque;
      pix_index   <= opaque ? rom_q : '0;
      pix_id      <= opaque ? id_d2 : '0;
    end
  end
endmodule

// File: tb/tb_turret_sprite_scheduler.sv
// Bench for turret_sprite_scheduler: directed scenarios plus random traffic,
// checked every cycle against a pixel-level reference of the sprite rules.
module tb_turret_sprite_scheduler;
  logic        vga_clk = 1'b0;
  logic        reset_n;
  logic [9:0]  DrawX, DrawY;
  logic        blank;
  logic        cfg_valid;
  logic        cfg_ready;
  logic [1:0]  cfg_id;
  logic [9:0]  cfg_x, cfg_y;
  logic        cfg_en;
  logic        cfg_commit;
  logic [10:0] rom_address;
  logic [2:0]  rom_q = 3'd0;
  logic        pix_valid;
  logic [2:0]  pix_index;
  logic [1:0]  pix_id;

  turret_sprite_scheduler dut (
    .vga_clk     (vga_clk),
    .reset_n     (reset_n),
    .DrawX       (DrawX),
    .DrawY       (DrawY),
    .blank       (blank),
    .cfg_valid   (cfg_valid),
    .cfg_ready   (cfg_ready),
    .cfg_id      (cfg_id),
    .cfg_x       (cfg_x),
    .cfg_y       (cfg_y),
    .cfg_en      (cfg_en),
    .cfg_commit  (cfg_commit),
    .rom_address (rom_address),
    .rom_q       (rom_q),
    .pix_valid   (pix_valid),
    .pix_index   (pix_index),
    .pix_id      (pix_id)
  );

  always #5 vga_clk = ~vga_clk;

  logic [2:0] rom_mem [0:2047];
  always @(posedge vga_clk) rom_q <= rom_mem[rom_address];

  typedef struct {
    bit v;
    int idx;
    int id;
    int addr;
  } exp_t;

  int m_x [4], m_y [4], s_x [4], s_y [4];
  bit m_en [4], s_en [4];
  bit m_pend;
  exp_t pipe[$];
  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin
      m_x[i] = 0; m_y[i] = 0; m_en[i] = 0;
      s_x[i] = 0; s_y[i] = 0; s_en[i] = 0;
    end
    m_pend = 0;
    pipe.delete();
    pipe.push_back('{v: 0, idx: 0, id: 0, addr: 0});
    pipe.push_back('{v: 0, idx: 0, id: 0, addr: 0});
  endtask

  // What the screen should show at the current pixel given the active set.
  task automatic model_pixel(output exp_t e);
    bit found = 0;
    int px = int'(DrawX);
    int py = int'(DrawY);
    e = '{v: 0, idx: 0, id: 0, addr: 0};
    if (blank) begin
      for (int i = 0; i < 4; i++) begin
        if (!found && m_en[i] && px >= m_x[i] && px - m_x[i] < 43 &&
            py >= m_y[i] && py - m_y[i] < 34) begin
          found  = 1;
          e.addr = (py - m_y[i]) * 43 + (px - m_x[i]);
          if (rom_mem[e.addr] != 3'd0) begin
            e.v   = 1;
            e.idx = int'(rom_mem[e.addr]);
            e.id  = i;
          end
        end
      end
    end
  endtask

  task automatic cycle();
    exp_t e;
    model_pixel(e);
    pipe.push_back(e);
    if (!m_pend) begin
      if (cfg_valid) begin
        s_x[cfg_id] = int'(cfg_x); s_y[cfg_id] = int'(cfg_y); s_en[cfg_id] = cfg_en;
      end
      if (cfg_commit) m_pend = 1;
    end else if (DrawX == 10'd0 && DrawY == 10'd0) begin
      for (int i = 0; i < 4; i++) begin
        m_x[i] = s_x[i]; m_y[i] = s_y[i]; m_en[i] = s_en[i];
      end
      m_pend = 0;
    end
    @(posedge vga_clk);
    #1;
    chk("rom_address", 32'(rom_address), 32'(pipe[$].addr));
    chk("cfg_ready", 32'(cfg_ready), 32'(!m_pend));
    e = pipe.pop_front();
    chk("pix_valid", 32'(pix_valid), 32'(e.v));
    chk("pix_index", 32'(pix_index), 32'(e.idx));
    chk("pix_id", 32'(pix_id), 32'(e.id));
  endtask

  task automatic px(input int x, input int y, input bit b);
    DrawX = 10'(x); DrawY = 10'(y); blank = b;
    cycle();
  endtask

  task automatic write_cfg(input int id, input int x, input int y, input bit en, input bit commit);
    DrawX = 10'd320; DrawY = 10'd240; blank = 1'b1;
    cfg_valid = 1'b1; cfg_id = 2'(id); cfg_x = 10'(x); cfg_y = 10'(y); cfg_en = en;
    cfg_commit = commit;
    cycle();
    cfg_valid = 1'b0; cfg_commit = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_rom_address"}, 32'(rom_address), 32'd0);
    chk({tag, "_pix_valid"}, 32'(pix_valid), 32'd0);
    chk({tag, "_pix_index"}, 32'(pix_index), 32'd0);
    chk({tag, "_pix_id"}, 32'(pix_id), 32'd0);
  endtask

  initial begin
    for (int i = 0; i < 2048; i++) rom_mem[i] = 3'($urandom_range(0, 7));
    rom_mem[0]    = 3'd0;
    rom_mem[1]    = 3'd7;
    rom_mem[1461] = 3'd6;

    reset_n = 1'b0;
    DrawX = '0; DrawY = '0; blank = 1'b0;
    cfg_valid = 1'b0; cfg_id = '0; cfg_x = '0; cfg_y = '0; cfg_en = 1'b0; cfg_commit = 1'b0;
    model_reset();
    #1;
    check_reset_outputs("reset");
    #11;
    reset_n = 1'b1;

    // No commit yet: nothing may be drawn anywhere.
    for (int r = 0; r < 4; r++) begin
      int rows [4] = '{0, 50, 240, 479};
      for (int x = 0; x < 800; x++) px(x, rows[r], x < 640);
    end

    // Single instance at (100,50).
    write_cfg(0, 100, 50, 1, 1);
    px(5, 5, 1);
    px(0, 0, 1);
    px(100, 50, 1);
    chk("addr_top_left", 32'(rom_address), 32'd0);
    px(142, 83, 1);
    chk("addr_bottom_right", 32'(rom_address), 32'd1461);
    px(143, 83, 1);
    chk("addr_right_miss", 32'(rom_address), 32'd0);
    px(99, 50, 1);
    chk("last_texel_valid", 32'(pix_valid), 32'd1);
    chk("last_texel_index", 32'(pix_index), 32'd6);
    chk("last_texel_id", 32'(pix_id), 32'd0);
    for (int y = 48; y < 86; y++)
      for (int x = 96; x < 147; x++) px(x, y, 1);

    // Two instances stacked: lowest ID wins even on a transparent texel.
    write_cfg(0, 200, 200, 1, 0);
    write_cfg(1, 200, 200, 1, 1);
    px(0, 0, 1);
    px(200, 200, 1);
    px(201, 200, 0);
    px(202, 200, 0);
    chk("stacked_transparent", 32'(pix_valid), 32'd0);
    for (int y = 198; y < 236; y++)
      for (int x = 198; x < 245; x++) px(x, y, 1);

    // Commit mid-frame: old position holds until frame start, writes ignored meanwhile.
    write_cfg(2, 300, 300, 1, 1);
    px(0, 0, 1);
    write_cfg(2, 10, 10, 1, 1);
    chk("pending_ready_low", 32'(cfg_ready), 32'd0);
    write_cfg(2, 400, 400, 1, 0);
    write_cfg(3, 20, 20, 1, 0);
    for (int i = 0; i < 40; i++) px(300 + i, 300 + (i % 34), 1);
    for (int i = 0; i < 40; i++) px(10 + i, 10 + (i % 34), 1);
    chk("pending_ready_still_low", 32'(cfg_ready), 32'd0);
    px(0, 0, 1);
    chk("ready_after_copy", 32'(cfg_ready), 32'd1);
    for (int i = 0; i < 40; i++) px(10 + i, 10 + (i % 34), 1);
    for (int i = 0; i < 40; i++) px(300 + i, 300 + (i % 34), 1);
    for (int i = 0; i < 40; i++) px(400 + i, 400 + (i % 34), 1);

    // Corner instance: a single visible pixel.
    write_cfg(3, 639, 479, 1, 1);
    px(0, 0, 1);
    for (int i = 0; i < 3; i++) px(639, 479, 0);
    rom_mem[0] = 3'd5;
    px(639, 479, 1);
    chk("corner_addr", 32'(rom_address), 32'd0);
    px(638, 479, 1);
    px(639, 478, 1);
    chk("corner_valid", 32'(pix_valid), 32'd1);
    chk("corner_id", 32'(pix_id), 32'd3);
    chk("corner_index", 32'(pix_index), 32'd5);
    px(639, 479, 0);
    px(638, 478, 1);
    px(637, 479, 1);
    chk("corner_blanked", 32'(pix_valid), 32'd0);
    for (int i = 0; i < 3; i++) px(639, 479, 0);
    rom_mem[0] = 3'd0;

    // Random traffic.
    for (int n = 0; n < 20000; n++) begin
      int r = int'($urandom_range(0, 99));
      int xx, yy;
      cfg_valid  = (r < 10);
      cfg_id     = 2'($urandom_range(0, 3));
      cfg_x      = 10'($urandom_range(0, 639));
      cfg_y      = 10'($urandom_range(0, 479));
      cfg_en     = ($urandom_range(0, 4) != 0);
      cfg_commit = ($urandom_range(0, 99) < 3);
      r = int'($urandom_range(0, 99));
      if (r < 2) begin
        xx = 0; yy = 0;
      end else if (r < 60) begin
        int k = int'($urandom_range(0, 3));
        xx = m_x[k] + int'($urandom_range(0, 48)) - 3;
        yy = m_y[k] + int'($urandom_range(0, 39)) - 3;
      end else begin
        xx = int'($urandom_range(0, 799));
        yy = int'($urandom_range(0, 524));
      end
      if (xx < 0) xx = 0;
      if (xx > 799) xx = 799;
      if (yy < 0) yy = 0;
      if (yy > 524) yy = 524;
      DrawX = 10'(xx); DrawY = 10'(yy);
      blank = (xx < 640) && (yy < 480) && ($urandom_range(0, 9) != 0);
      cycle();
    end
    cfg_valid = 1'b0; cfg_commit = 1'b0;
    px(0, 0, 1);

    // Reset during PENDING discards the commit and clears everything at once.
    write_cfg(0, 50, 60, 1, 1);
    px(0, 0, 1);
    write_cfg(0, 300, 300, 1, 1);
    px(51, 60, 1);
    px(51, 60, 1);
    px(51, 60, 1);
    chk("pre_reset_valid", 32'(pix_valid), 32'd1);
    chk("pre_reset_addr", 32'(rom_address), 32'd1);
    reset_n = 1'b0;
    #1;
    check_reset_outputs("async_reset");
    #2;
    reset_n = 1'b1;
    model_reset();
    px(51, 60, 1);
    chk("post_reset_ready", 32'(cfg_ready), 32'd1);
    px(0, 0, 1);
    px(51, 60, 1);
    px(301, 300, 1);
    px(302, 300, 1);
    px(303, 300, 1);
    chk("post_reset_no_pix", 32'(pix_valid), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
